// File: rtl/cam_pkg.sv
// Shared definitions for the OV7670 capture path: FSM states, RGB565 layout
// and the luma coefficients used by the grayscale converter.
package cam_pkg;

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        SKIP      = 2'd1,
        IDLE      = 2'd2,
        CAPTURE   = 2'd3
    } cam_state_t;

    localparam int unsigned PIX_W  = 16;
    localparam int unsigned WORD_W = 32;

    // RGB565 field positions, shared with the display-side unpack
    localparam int unsigned R_MSB = 15;
    localparam int unsigned R_LSB = 11;
    localparam int unsigned G_MSB = 10;
    localparam int unsigned G_LSB = 5;
    localparam int unsigned B_MSB = 4;
    localparam int unsigned B_LSB = 0;

    typedef struct packed {
        logic [R_MSB-R_LSB:0] r;
        logic [G_MSB-G_LSB:0] g;
        logic [B_MSB-B_LSB:0] b;
    } rgb565_t;

    localparam int unsigned GRAY_CR = 77;
    localparam int unsigned GRAY_CG = 150;
    localparam int unsigned GRAY_CB = 29;

endpackage

// File: rtl/rgb565_gray.sv
// One-stage RGB565 -> RGB565-encoded grayscale converter with pass-through,
// so colour and gray pixels leave with the same one-cycle latency.
module rgb565_gray
    import cam_pkg::*;
(
    input  logic        cam_pclk,
    input  logic        cam_rst,
    input  logic        gray_en,
    input  logic        pix_vld,
    input  logic        pix_odd,
    input  logic [15:0] pix,
    output logic        res_vld,
    output logic        res_odd,
    output logic [15:0] res
);

    rgb565_t     px;
    logic [7:0]  r8;
    logic [7:0]  g8;
    logic [7:0]  b8;
    logic [15:0] sum;
    logic [7:0]  y;
    logic [15:0] gray_pix;

    assign px  = rgb565_t'(pix);
    assign r8  = {px.r, px.r[4:2]};
    assign g8  = {px.g, px.g[5:4]};
    assign b8  = {px.b, px.b[4:2]};
    // Coefficients sum to 256, so the 16-bit sum cannot overflow
    assign sum = 16'(GRAY_CR) * 16'(r8) + 16'(GRAY_CG) * 16'(g8) + 16'(GRAY_CB) * 16'(b8);
    assign y   = sum[15:8];
    assign gray_pix = {y[7:3], y[7:2], y[7:3]};

    always_ff @(posedge cam_pclk or posedge cam_rst) begin
        if (cam_rst) begin
            res_vld <= 1'b0;
            res_odd <= 1'b0;
            res     <= 16'd0;
        end else begin
            res_vld <= pix_vld;
            res_odd <= pix_odd;
            if (pix_vld) begin
                res <= gray_en ? gray_pix : pix;
            end
        end
    end

endmodule

// File: rtl/cam_ddr_write.sv
// OV7670 capture writer: assembles RGB565 pixels from the byte stream, packs
// pixel pairs into 32-bit DDR words and frames them with an address reset.
module cam_ddr_write
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned FRAME_SKIP = 2
) (
    input  logic        cam_pclk,
    input  logic        cam_rst,
    input  logic        ddr_init_done,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        gray_sel,
    output logic        ddr_wren,
    output logic [31:0] ddr_data,
    output logic        ddr_addr_set,
    output logic        cam_framesync,
    output logic        frame_err
);

    localparam int unsigned CNT_W = 16;

    cam_state_t       state;
    cam_state_t       state_nxt;
    logic             vsync_q;
    logic             href_q;
    logic             vs_rise;
    logic             vs_fall;
    logic             capture;
    logic             line_end;
    logic             skip_last;
    logic [3:0]       skip_cnt;
    logic             gray_q;
    logic             phase;
    logic             pair;
    logic [7:0]       byte_hi;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] line_cnt;
    logic             pix_vld;
    logic             pix_odd;
    logic [15:0]      pix;
    logic             res_vld;
    logic             res_odd;
    logic [15:0]      res;
    logic [15:0]      even_pix;

    assign vs_rise       = cam_vsync & ~vsync_q;
    assign vs_fall       = ~cam_vsync & vsync_q;
    assign capture       = (state == CAPTURE);
    assign line_end      = capture & href_q & ~cam_href;
    assign skip_last     = (({1'b0, skip_cnt} + 5'd1) == 5'(FRAME_SKIP));
    assign cam_framesync = capture;

    always_ff @(posedge cam_pclk or posedge cam_rst) begin
        if (cam_rst) begin
            state <= WAIT_INIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_INIT: if (ddr_init_done) state_nxt = SKIP;
            SKIP:      if (FRAME_SKIP == 0 || (vs_rise && skip_last)) state_nxt = IDLE;
            IDLE:      if (vs_fall) state_nxt = CAPTURE;
            CAPTURE:   if (vs_rise) state_nxt = IDLE;
            default:   state_nxt = WAIT_INIT;
        endcase
    end

    // Frame/line bookkeeping and byte-to-pixel assembly
    always_ff @(posedge cam_pclk or posedge cam_rst) begin
        if (cam_rst) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            skip_cnt     <= 4'd0;
            ddr_addr_set <= 1'b0;
            gray_q       <= 1'b0;
            frame_err    <= 1'b0;
            phase        <= 1'b0;
            pair         <= 1'b0;
            byte_hi      <= 8'd0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            pix_vld      <= 1'b0;
            pix_odd      <= 1'b0;
            pix          <= 16'd0;
        end else begin
            vsync_q      <= cam_vsync;
            href_q       <= cam_href;
            ddr_addr_set <= 1'b0;
            pix_vld      <= 1'b0;

            if (state == SKIP && vs_rise) begin
                skip_cnt <= skip_cnt + 4'd1;
            end

            if (state == IDLE && vs_fall) begin
                ddr_addr_set <= 1'b1;
                gray_q       <= gray_sel;
                line_cnt     <= '0;
                pix_cnt      <= '0;
                pair         <= 1'b0;
            end

            if (capture && vs_rise && line_cnt != CNT_W'(V_ACTIVE)) begin
                frame_err <= 1'b1;
            end

            if (!cam_href) begin
                phase <= 1'b0;
            end else if (capture) begin
                phase <= ~phase;
                if (!phase) begin
                    byte_hi <= cam_data;
                end else begin
                    pix_cnt <= pix_cnt + CNT_W'(1);
                    pair    <= ~pair;
                    // Lines past the frame height are counted but never written
                    if (line_cnt < CNT_W'(V_ACTIVE)) begin
                        pix_vld <= 1'b1;
                        pix_odd <= pair;
                        pix     <= {byte_hi, cam_data};
                    end
                end
            end

            if (line_end) begin
                if (pix_cnt != CNT_W'(H_ACTIVE) || line_cnt >= CNT_W'(V_ACTIVE)) begin
                    frame_err <= 1'b1;
                end
                line_cnt <= line_cnt + CNT_W'(1);
                pix_cnt  <= '0;
                pair     <= 1'b0;
            end
        end
    end

    rgb565_gray u_gray (
        .cam_pclk (cam_pclk),
        .cam_rst  (cam_rst),
        .gray_en  (gray_q),
        .pix_vld  (pix_vld),
        .pix_odd  (pix_odd),
        .pix      (pix),
        .res_vld  (res_vld),
        .res_odd  (res_odd),
        .res      (res)
    );

    // Hold the even pixel; the odd pixel completes and issues the word
    always_ff @(posedge cam_pclk or posedge cam_rst) begin
        if (cam_rst) begin
            ddr_wren <= 1'b0;
            ddr_data <= 32'd0;
            even_pix <= 16'd0;
        end else begin
            ddr_wren <= 1'b0;
            if (res_vld) begin
                if (res_odd) begin
                    ddr_wren <= 1'b1;
                    ddr_data <= {even_pix, res};
                end else begin
                    even_pix <= res;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_ddr_write.sv
// Randomized bench for cam_ddr_write against a frame-level reference model
// (4x2 frames, two skipped frames after init).
module tb_cam_ddr_write;

    localparam int unsigned H  = 4;
    localparam int unsigned V  = 2;
    localparam int unsigned FS = 2;

    logic        cam_pclk      = 1'b0;
    logic        cam_rst       = 1'b1;
    logic        ddr_init_done = 1'b0;
    logic        cam_vsync     = 1'b0;
    logic        cam_href      = 1'b0;
    logic [7:0]  cam_data      = 8'd0;
    logic        gray_sel      = 1'b0;
    logic        ddr_wren;
    logic [31:0] ddr_data;
    logic        ddr_addr_set;
    logic        cam_framesync;
    logic        frame_err;

    cam_ddr_write #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .FRAME_SKIP (FS)
    ) dut (
        .cam_pclk      (cam_pclk),
        .cam_rst       (cam_rst),
        .ddr_init_done (ddr_init_done),
        .cam_vsync     (cam_vsync),
        .cam_href      (cam_href),
        .cam_data      (cam_data),
        .gray_sel      (gray_sel),
        .ddr_wren      (ddr_wren),
        .ddr_data      (ddr_data),
        .ddr_addr_set  (ddr_addr_set),
        .cam_framesync (cam_framesync),
        .frame_err     (frame_err)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t          exp_q[$];
    wr_t          obs_q[$];
    logic [15:0]  px_q[$];
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;

    // Reference model state
    int rises_m = 0;
    int lines_m = 0;
    bit capt_m  = 1'b0;
    bit gray_m  = 1'b0;
    bit err_m   = 1'b0;

    always #5 cam_pclk = ~cam_pclk;

    always @(posedge cam_pclk) cyc <= cyc + 1;

    always @(negedge cam_pclk) begin
        if (ddr_wren === 1'b1) obs_q.push_back(wr_t'{ddr_data, cyc});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge cam_pclk);
        #1;
    endtask

    // Luma from 8-bit expanded channels, repacked as RGB565 gray
    function automatic logic [15:0] gray_ref(input logic [15:0] p);
        int r, g, b, y;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        y = (77 * (r * 8 + r / 4) + 150 * (g * 4 + g / 16) + 29 * (b * 8 + b / 4)) / 256;
        return 16'((y / 8) * 2048 + (y / 4) * 32 + (y / 8));
    endfunction

    function automatic logic [15:0] conv(input logic [15:0] p);
        return gray_m ? gray_ref(p) : p;
    endfunction

    task automatic compare_writes();
        wr_t o, e;
        check("n_writes", obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check("wr_data", o.data, e.data);
            check("wr_cycle", o.cyc, e.cyc);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic fill_rand(input int n);
        px_q.delete();
        for (int i = 0; i < n; i++) px_q.push_back(16'($urandom));
    endtask

    task automatic do_reset();
        wr_t keep[$];
        cam_rst   = 1'b1;
        cam_href  = 1'b0;
        cam_vsync = 1'b0;
        #1;
        check("rst_wren", ddr_wren, 0);
        check("rst_data", ddr_data, 0);
        check("rst_addr_set", ddr_addr_set, 0);
        check("rst_framesync", cam_framesync, 0);
        check("rst_frame_err", frame_err, 0);
        // Writes not yet on the outputs at reset are flushed
        foreach (exp_q[i]) if (exp_q[i].cyc < cyc) keep.push_back(exp_q[i]);
        exp_q = keep;
        compare_writes();
        rises_m = 0;
        lines_m = 0;
        capt_m  = 1'b0;
        err_m   = 1'b0;
        repeat (2) tick();
        cam_rst = 1'b0;
        repeat (3) tick();
    endtask

    // Drive one line from px_q; rst_at >= 0 asserts reset instead of that byte
    task automatic send_line(input int rst_at);
        int n;
        bit line_ok;
        n = px_q.size();
        line_ok = capt_m && (lines_m < int'(V));
        check("framesync", cam_framesync, capt_m);
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < 2; b++) begin
                if (2 * i + b == rst_at) begin
                    do_reset();
                    return;
                end
                cam_href = 1'b1;
                cam_data = (b == 0) ? px_q[i][15:8] : px_q[i][7:0];
                if (b == 1 && (i % 2) == 1 && line_ok)
                    exp_q.push_back(wr_t'{{conv(px_q[i-1]), conv(px_q[i])}, cyc + 3});
                tick();
            end
        end
        cam_href = 1'b0;
        if (capt_m) begin
            if (n != int'(H) || lines_m >= int'(V)) err_m = 1'b1;
            lines_m++;
        end
        repeat (2 + $urandom_range(0, 3)) tick();
    endtask

    task automatic send_vsync();
        bit start;
        cam_vsync = 1'b1;
        if (capt_m) begin
            if (lines_m != int'(V)) err_m = 1'b1;
            capt_m = 1'b0;
        end else if (rises_m < int'(FS)) begin
            rises_m++;
        end
        repeat (3) tick();
        cam_vsync = 1'b0;
        tick();
        start = (rises_m >= int'(FS));
        check("addr_set", ddr_addr_set, start);
        if (start) begin
            capt_m  = 1'b1;
            gray_m  = gray_sel;
            lines_m = 0;
        end
        tick();
        check("addr_set_pulse", ddr_addr_set, 0);
        compare_writes();
        check("frame_err", frame_err, err_m);
    endtask

    task automatic run_frame(input int nl, input bit rnd);
        int lens[5] = '{3, 4, 4, 4, 5};
        for (int l = 0; l < nl; l++) begin
            fill_rand(rnd ? lens[$urandom_range(0, 4)] : int'(H));
            if (rnd && l == 0) gray_sel = 1'($urandom_range(0, 1));
            send_line(-1);
        end
        send_vsync();
    endtask

    initial begin
        ddr_init_done = 1'b1;
        repeat (3) tick();
        check("init_wren", ddr_wren, 0);
        check("init_data", ddr_data, 0);
        check("init_addr_set", ddr_addr_set, 0);
        check("init_framesync", cam_framesync, 0);
        check("init_frame_err", frame_err, 0);
        cam_rst = 1'b0;
        repeat (3) tick();

        // Two skipped frames, then a colour frame with a directed first word
        run_frame(V, 1'b0);
        run_frame(V, 1'b0);
        px_q = '{16'hF800, 16'h07E0, 16'h1234, 16'hABCD};
        send_line(-1);
        fill_rand(H);
        gray_sel = 1'b1;
        send_line(-1);
        send_vsync();

        // Gray frame with known pixels; toggle gray_sel back mid-frame
        px_q = '{16'hFFFF, 16'h0000, 16'hF800, 16'h0000};
        send_line(-1);
        gray_sel = 1'b0;
        fill_rand(H);
        send_line(-1);
        send_vsync();

        // Colour frame, select gray mid-frame for the next one
        fill_rand(H);
        send_line(-1);
        gray_sel = 1'b1;
        fill_rand(H);
        send_line(-1);
        send_vsync();

        // Short line drops its unpaired pixel and latches frame_err
        fill_rand(3);
        send_line(-1);
        fill_rand(H);
        send_line(-1);
        send_vsync();
        run_frame(V, 1'b0);

        // Random geometry and gray selection
        for (int f = 0; f < 8; f++) run_frame($urandom_range(1, 3), 1'b1);

        // Reset in the middle of a captured line, then re-apply frame skip
        fill_rand(H);
        send_line(7);
        run_frame(V, 1'b0);
        run_frame(V, 1'b0);
        run_frame(V, 1'b0);
        run_frame(V, 1'b1);

        repeat (5) tick();
        compare_writes();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cam_ddr_write.md
# cam_ddr_write

Camera-side capture writer for the OV7670 → DDR → VGA path, clocked by the sensor pixel clock. It samples the 8-bit OV7670 byte stream and assembles RGB565 pixels, optionally converting each pixel to RGB565-encoded grayscale. Each pair of pixels is packed into a 32-bit DDR word and issued as a write strobe. It also generates the per-frame DDR write-address reset, which mirrors the read-side `ddr_addr_set`/`ddr_rden` scheme used by the VGA display.

## Interface
Parameters:
- `H_ACTIVE`, 640, pixels per line (even)
- `V_ACTIVE`, 480, lines per frame
- `FRAME_SKIP`, 2, frames discarded after `ddr_init_done` (sensor settle), 0..15

Ports:
- `cam_pclk` in 1, sensor pixel clock; all logic on rising edge
- `cam_rst` in 1, asynchronous, active-high reset
- `ddr_init_done` in 1, DDR controller calibrated
- `cam_vsync` in 1, OV7670 VSYNC, active-high pulse between frames
- `cam_href` in 1, line-valid
- `cam_data` in 8, sensor byte
- `gray_sel` in 1, 1 = write grayscale, 0 = write colour
- `ddr_wren` out 1, one-cycle write strobe
- `ddr_data` out 32, write word; first pixel in [31:16], second in [15:0]
- `ddr_addr_set` out 1, one-cycle pulse, DDR write address to frame base
- `cam_framesync` out 1, high while a captured frame is in progress
- `frame_err` out 1, sticky geometry error

## Operation
- Reset values: all outputs 0; state `WAIT_INIT`; all counters 0.
- States:
  - `WAIT_INIT`: go to `SKIP` when `ddr_init_done`=1.
  - `SKIP`: count `cam_vsync` rising edges. After `FRAME_SKIP` edges, go to `IDLE`. When `FRAME_SKIP`=0, go directly to `IDLE`.
  - `IDLE`: on a `cam_vsync` falling edge:
    - pulse `ddr_addr_set`;
    - latch `gray_sel` into `gray_q`;
    - clear the line and word counters;
    - go to `CAPTURE`.
  - `CAPTURE`: on a `cam_vsync` rising edge:
    - check that the line count equals `V_ACTIVE`; otherwise set `frame_err`;
    - go to `IDLE`.
- `cam_framesync` = (state == `CAPTURE`).
- Byte sampling: a byte is sampled when `cam_href`=1 in `CAPTURE`. The byte phase toggles on each sampled byte and clears whenever `cam_href`=0.
  - Phase 0 byte = {R[4:0], G[5:3]}.
  - Phase 1 byte = {G[2:0], B[4:0]}; this byte completes the pixel.
- Pixel pairing: a pair toggle alternates on each completed pixel and clears at each line start. The even pixel is held; the odd pixel completes the word.
- Gray path (when `gray_q`=1):
  - R8={R,R[4:2]}, G8={G,G[5:4]}, B8={B,B[4:2]}.
  - Y = (77·R8 + 150·G8 + 29·B8) >> 8, computed with a 16-bit sum; truncate, no rounding.
  - Output pixel = {Y[7:3], Y[7:2], Y[7:3]}.
- Colour path: the pixel passes through unchanged, delayed to match the gray path latency.
- Line end (`cam_href` falling in `CAPTURE`):
  - pixel count ≠ `H_ACTIVE` → set `frame_err`;
  - a dangling phase-0 byte or an unpaired pixel is discarded (no write);
  - increment the line count.
- Lines beyond `V_ACTIVE` are not written; this also sets `frame_err`.
- `frame_err` clears only on `cam_rst`.
- `gray_sel` changes mid-frame take effect at the next `ddr_addr_set`.

## Timing
- Write latency: the rising edge that samples the phase-1 byte of an odd pixel is edge N. `ddr_wren`=1 and `ddr_data` are valid in the cycle after edge N+2. This is a fixed 2-cycle pipeline for both gray and colour.
- `ddr_data` holds its value until the next `ddr_wren`.
- Write rate: `ddr_wren` is at most 1 in every 4 cycles, and a full frame produces exactly H_ACTIVE·V_ACTIVE/2 strobes (153600 at defaults).
- `ddr_addr_set` is asserted the cycle after the edge that detects the `cam_vsync` falling edge. It always precedes the frame's first `ddr_wren` by at least 1 cycle.
- Edge detection uses a 1-cycle registered `cam_vsync`.
- Writes still in the pipeline when `cam_vsync` rises complete normally.
- Asynchronous `cam_rst` mid-frame:
  - outputs drop to 0 immediately and the pipeline is flushed;
  - the block returns to `WAIT_INIT` and re-applies `FRAME_SKIP`.
- `ddr_init_done` deasserting does not abort a frame in progress; it is sampled only in `WAIT_INIT`.

## Structure
- Shared package `cam_pkg`:
  - state encoding (`WAIT_INIT`, `SKIP`, `IDLE`, `CAPTURE`);
  - gray coefficients 77/150/29;
  - RGB565 field positions, shared with `vga_disp`'s unpack.
- One sub-module, `rgb565_gray`: a 1-stage registered converter with pass-through mux, giving a fixed 1-cycle latency for either mode.
- The FSM, byte assembly, pair packing and counters stay in the top level.

## Test plan
- Reset, `ddr_init_done`=1, `FRAME_SKIP`=2, three 4×2 frames (`H_ACTIVE`=4, `V_ACTIVE`=2) → frames 1–2 produce no writes; frame 3 produces one `ddr_addr_set` then exactly 4 `ddr_wren`, and `frame_err`=0.
- Colour mode, bytes F8,00,07,E0 → `ddr_data`=F800_07E0 exactly 2 cycles after the E0 sampling edge.
- Gray mode, pixels FFFF and 0000 → `ddr_data`=FFFF_0000. Pixel F800 alone → Y=0x4C, output 0x4A69.
- Line of 3 pixels (`H_ACTIVE`=4) → 1 write for that line, the unpaired pixel is dropped, and `frame_err`=1 stays set through the next good frame.
- Assert `cam_rst` mid-line → all outputs 0 the same cycle and no further writes until `FRAME_SKIP` frames pass after reset release.
- Toggle `gray_sel` mid-frame → the current frame stays colour and the next frame after `ddr_addr_set` is gray.
